// File: rtl/lc3b_types_pkg.sv
// lc3b_types: shared LC-3b word/opcode types plus the fetch-stage state encoding
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0] lc3b_opcode;
  typedef enum logic [1:0] {FETCH, FLUSH, VALID} ifetch_state_t;
  localparam lc3b_word LC3B_INSTR_BYTES = 16'd2;
endpackage

// File: rtl/ifetch_stage_sat_counter.sv
// sat_counter: event counter that sticks at its all-ones value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  // count qualifying events, never wrapping past all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: LC-3b fetch front end with PC, imem handshake, stall and redirect; IFETCH_PERF_EN adds perf counters
module ifetch_stage
  import lc3b_types::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [3:0]  if_opcode,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_wait_cycles,
  output logic [15:0] perf_flushes
`endif
);
  ifetch_state_t state, state_n;
  lc3b_word pc, pc_n, fetch_addr, fetch_addr_n, ir_n, ipc_n;
  lc3b_word rpc;
  assign rpc = {redirect_pc[15:1], 1'b0};
  assign imem_read = state == FETCH || state == FLUSH;
  assign imem_address = fetch_addr;
  assign if_valid = state == VALID;
  assign if_opcode = if_ir[15:12];
  assign if_pc_plus2 = if_pc + LC3B_INSTR_BYTES;
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      fetch_addr <= RESET_PC;
      if_ir <= '0;
      if_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fetch_addr <= fetch_addr_n;
      if_ir <= ir_n;
      if_pc <= ipc_n;
    end
  // next state: a redirect always wins, a response in FLUSH is thrown away
  always_comb begin
    state_n = state;
    pc_n = pc;
    fetch_addr_n = fetch_addr;
    ir_n = if_ir;
    ipc_n = if_pc;
    case (state)
      FETCH:
        if (redirect) begin
          pc_n = rpc;
          fetch_addr_n = imem_resp ? rpc : fetch_addr;
          state_n = imem_resp ? FETCH : FLUSH;
        end else if (imem_resp) begin
          ir_n = imem_rdata;
          ipc_n = fetch_addr;
          pc_n = fetch_addr + LC3B_INSTR_BYTES;
          state_n = VALID;
        end
      FLUSH: begin
        pc_n = redirect ? rpc : pc;
        fetch_addr_n = imem_resp ? (redirect ? rpc : pc) : fetch_addr;
        state_n = imem_resp ? FETCH : FLUSH;
      end
      VALID:
        if (redirect) begin
          pc_n = rpc;
          fetch_addr_n = rpc;
          state_n = FETCH;
        end else if (!stall) begin
          fetch_addr_n = pc;
          state_n = FETCH;
        end
      default: state_n = FETCH;
    endcase
  end
`ifdef IFETCH_PERF_EN
  sat_counter #(.WIDTH(16)) u_wait (
    .clk(clk), .rst_n(rst_n), .inc(imem_read && !imem_resp), .count(perf_wait_cycles)
  );
  sat_counter #(.WIDTH(16)) u_flush (
    .clk(clk), .rst_n(rst_n), .inc(redirect), .count(perf_flushes)
  );
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed plus randomized checks of ifetch_stage against a transaction-level model
module tb_ifetch_stage;
  logic clk = 0, rst_n = 0;
  logic imem_read, imem_resp = 0, stall = 0, redirect = 0, if_valid;
  logic [15:0] imem_address, imem_rdata = 0, redirect_pc = 0, if_ir, if_pc, if_pc_plus2;
  logic [3:0] if_opcode;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_wait_cycles, perf_flushes;
`endif
  int n_cmp = 0, n_err = 0;
  bit m_valid, m_drop;
  logic [15:0] m_pc, m_fa, m_ir, m_ipc;
  int m_wait, m_fl;
  always #5 clk = ~clk;
  ifetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ir(if_ir), .if_opcode(if_opcode),
    .if_pc(if_pc), .if_pc_plus2(if_pc_plus2)
`ifdef IFETCH_PERF_EN
    , .perf_wait_cycles(perf_wait_cycles), .perf_flushes(perf_flushes)
`endif
  );
  // a response is only legal while a request is open and no instruction is held
  always @(posedge clk)
    if (rst_n && imem_resp) assert (imem_read && !if_valid) else $error("illegal imem response");
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_model();
    check("imem_read", imem_read, !m_valid);
    check("imem_address", imem_address, m_fa);
    check("if_valid", if_valid, m_valid);
    check("if_ir", if_ir, m_ir);
    check("if_opcode", if_opcode, m_ir[15:12]);
    check("if_pc", if_pc, m_ipc);
    check("if_pc_plus2", if_pc_plus2, 16'(m_ipc + 16'd2));
`ifdef IFETCH_PERF_EN
    check("perf_wait", perf_wait_cycles, m_wait);
    check("perf_flushes", perf_flushes, m_fl);
`endif
  endtask
  task automatic cycle(input bit r, input bit s, input bit d, input logic [15:0] p, input logic [15:0] data);
    logic [15:0] t;
    imem_resp = r;
    stall = s;
    redirect = d;
    redirect_pc = p;
    imem_rdata = r ? data : 16'($urandom);
    t = {p[15:1], 1'b0};
    @(posedge clk);
    if (!m_valid && !r && m_wait < 16'hFFFF) m_wait++;
    if (d && m_fl < 16'hFFFF) m_fl++;
    if (m_valid) begin
      if (d) begin m_valid = 0; m_pc = t; m_fa = t; end
      else if (!s) begin m_valid = 0; m_fa = m_pc; end
    end else if (r) begin
      if (m_drop || d) begin
        if (d) m_pc = t;
        m_fa = m_pc;
        m_drop = 0;
      end else begin
        m_valid = 1; m_ir = data; m_ipc = m_fa; m_pc = m_fa + 16'd2;
      end
    end else if (d) begin
      m_pc = t; m_drop = 1;
    end
    #1;
    check_model();
  endtask
  initial begin
    m_valid = 0; m_drop = 0; m_pc = 0; m_fa = 0; m_ir = 0; m_ipc = 0; m_wait = 0; m_fl = 0;
    #12;
    check("rst_valid", if_valid, 0);
    check("rst_read", imem_read, 1);
    check("rst_pc_plus2", if_pc_plus2, 16'h0002);
    check_model();
    @(posedge clk); #1 rst_n = 1;
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 16'h1234);
    check("t1_ir", if_ir, 16'h1234);
    check("t1_opcode", if_opcode, 4'h1);
    check("t1_pc_plus2", if_pc_plus2, 16'h0002);
    cycle(0, 0, 0, 0, 0);
    check("t1_next_addr", imem_address, 16'h0002);
    cycle(1, 0, 0, 0, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      check("t2_hold_read", imem_read, 0);
      check("t2_hold_ir", if_ir, 16'hABCD);
    end
    cycle(0, 0, 0, 0, 0);
    check("t2_next_addr", imem_address, 16'h0004);
    cycle(0, 0, 1, 16'h3001, 0);
    check("t3_addr_held", imem_address, 16'h0004);
    cycle(1, 0, 0, 0, 16'h7777);
    check("t3_dropped", if_valid, 0);
    check("t3_new_addr", imem_address, 16'h3000);
    cycle(1, 0, 1, 16'h4000, 16'h5555);
    check("t4_addr", imem_address, 16'h4000);
    check("t4_valid", if_valid, 0);
    cycle(1, 0, 0, 0, 16'h2222);
    cycle(0, 1, 1, 16'h5000, 0);
    check("t5_valid", if_valid, 0);
    check("t5_addr", imem_address, 16'h5000);
    cycle(1, 0, 0, 0, 16'h1111);
    cycle(0, 1, 1, 16'hFFFF, 0);
    cycle(1, 1, 0, 0, 16'h0F0F);
    check("t6_pc", if_pc, 16'hFFFE);
    check("t6_plus2_wrap", if_pc_plus2, 16'h0000);
    cycle(0, 0, 0, 0, 0);
    check("t6_wrap_addr", imem_address, 16'h0000);
    for (int i = 0; i < 3000; i++)
      cycle(!m_valid && ($urandom_range(2) == 0), $urandom_range(1) == 1,
            $urandom_range(7) == 0, 16'($urandom), 16'($urandom));
    rst_n = 0;
    #1;
    check("mid_rst_valid", if_valid, 0);
    check("mid_rst_addr", imem_address, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch front end of the LC-3b pipeline.
- Owns the PC and issues read requests to the instruction memory/cache over the read/resp handshake.
- Captures each returned instruction word and presents it, with its opcode field, to the decode stage that indexes the control ROM.
- Honours downstream stall and branch/jump redirect.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_read  out  1  instruction read request; held high until imem_resp.
- imem_address  out  16  byte address of the request; stable while imem_read is high.
- imem_rdata  in  16  instruction word; valid when imem_resp is high.
- imem_resp  in  1  one-cycle response strobe.
- stall  in  1  decode not accepting; hold the current instruction.
- redirect  in  1  one-cycle pulse: discard in-flight/held instruction, restart at redirect_pc.
- redirect_pc  in  16  target PC; bit 0 ignored (forced 0).
- if_valid  out  1  if_ir/if_pc hold a live instruction.
- if_ir  out  16  fetched instruction word.
- if_opcode  out  4 (lc3b_opcode)  if_ir[15:12].
- if_pc  out  16  address of if_ir.
- if_pc_plus2  out  16  if_pc + 2, mod 2^16.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, fetch_addr=RESET_PC, if_valid=0, if_ir=0, if_pc=0. if_pc_plus2 derives from if_pc, so it resets to 2. imem_read is 1 in the first cycle after reset release.
- Registers:
  - pc: next address to fetch.
  - fetch_addr: drives imem_address.
  - Output registers if_ir and if_pc.
- imem_read = (state==FETCH || state==FLUSH). imem_address = fetch_addr always.
- FETCH:
  - resp & !redirect: if_ir<=imem_rdata, if_pc<=fetch_addr, pc<=fetch_addr+2, if_valid<=1, go VALID.
  - resp & redirect: discard data, pc<=fetch_addr<=redirect_pc, stay FETCH. A new request is issued next cycle.
  - !resp & redirect: pc<=redirect_pc, go FLUSH. fetch_addr is unchanged because the request is still outstanding.
  - otherwise: hold.
- FLUSH (old request outstanding, result to be dropped):
  - redirect: pc<=redirect_pc, the latest redirect wins.
  - resp: fetch_addr<=(redirect ? redirect_pc : pc), go FETCH.
  - if_valid stays 0.
- VALID (if_valid=1, imem_read=0):
  - redirect has priority over stall: if_valid<=0, pc<=fetch_addr<=redirect_pc, go FETCH.
  - !stall: the instruction is consumed at this edge. if_valid<=0, fetch_addr<=pc, go FETCH.
  - stall: hold all outputs unchanged.
- Throughput and latency:
  - At most one instruction per 2 cycles, one of which is the VALID cycle.
  - With a 1-cycle memory, the first if_valid rises 2 cycles after reset release.
- Arithmetic: 16-bit unsigned, wraps at 16'hFFFE -> 16'h0000.
- A response while in VALID is illegal and must be flagged by a bench assertion. A response with imem_read low is likewise illegal.
- If reset asserts mid-request, the memory is reset by the same rst_n, so no stale response is expected.

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined, adds these output ports:
  - perf_wait_cycles, 16 bits: counts cycles with imem_read=1 & imem_resp=0.
  - perf_flushes, 16 bits: counts redirect pulses that discard an instruction (FETCH/FLUSH/VALID).
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- lc3b_types package: lc3b_word (16b), lc3b_opcode already exist. Add ifetch_state_t enum {FETCH, FLUSH, VALID} and constant LC3B_INSTR_BYTES = 2.
- Sub-module sat_counter (WIDTH param, inc, count out), instantiated twice, only under IFETCH_PERF_EN. Everything else stays in one module.

Test Plan:
- Reset release, memory returns 16'h1234 @0x0000 after 1 wait cycle, stall=0 -> if_valid=1 with if_ir=16'h1234, if_opcode=4'h1, if_pc=0, if_pc_plus2=2; next request address 0x0002.
- Stall held 3 cycles during VALID -> if_ir/if_pc unchanged, imem_read=0 throughout; after stall drops, next fetch is at if_pc+2.
- Redirect to 0x3001 while a request is outstanding (no resp) -> imem_address stays old until resp, response dropped (if_valid stays 0), then request at 0x3000.
- Redirect coincident with imem_resp in FETCH -> data discarded, next-cycle imem_address=redirect_pc, if_valid=0.
- Redirect and stall together in VALID -> if_valid drops next cycle, fetch at redirect_pc.
- PC=0xFFFE fetch -> if_pc_plus2=0x0000, next request at 0x0000. With IFETCH_PERF_EN, 5 wait cycles -> perf_wait_cycles=5; 0xFFFF+1 saturates.
